uart_tx_fifo: RTL

UART_TX_FIFO -- requirements
Module: uart_tx_fifo

---
 rtl/uart_pkg.sv | 17 +
 rtl/uart_tx_fifo_if.sv | 37 +++
 rtl/tx_fifo.sv | 66 ++++++
 rtl/uart_tx_fifo.sv | 154 +++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared types and defaults for the buffered UART transmitter.
//   uart_state_e      : transmitter FSM states
//   CLKS_PER_BIT_DEF  : default bit period in clk cycles (50 MHz / 115200)
//   FIFO_DEPTH_DEF    : default transmit buffer depth in bytes
package uart_pkg;

    localparam int unsigned CLKS_PER_BIT_DEF = 434;
    localparam int unsigned FIFO_DEPTH_DEF   = 8;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } uart_state_e;

endpackage

// File: rtl/uart_tx_fifo_if.sv
// Byte-enqueue and status bundle of the buffered UART transmitter.
//   din      : byte to enqueue
//   wr       : single-cycle enqueue strobe
//   tx       : serial line, idles high
//   full     : buffer holds FIFO_DEPTH bytes
//   empty    : buffer holds no bytes
//   busy     : a frame is on the line
//   count    : buffer occupancy
//   overflow : sticky, a write was dropped
// master drives din/wr; slave is the transmitter.
interface uart_tx_fifo_if
    import uart_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = FIFO_DEPTH_DEF
);
    localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

    logic [7:0]    din;
    logic          wr;
    logic          tx;
    logic          full;
    logic          empty;
    logic          busy;
    logic [CW-1:0] count;
    logic          overflow;

    modport master (
        output din, wr,
        input  tx, full, empty, busy, count, overflow
    );

    modport slave (
        input  din, wr,
        output tx, full, empty, busy, count, overflow
    );

endinterface

// File: rtl/tx_fifo.sv
// Synchronous byte FIFO feeding the UART transmitter.
//   clk, reset : clock, asynchronous active-low reset
//   din, wr    : write data and strobe (dropped while full)
//   rd         : pop strobe (ignored while empty)
//   dout       : head byte, valid while not empty
//   count      : occupancy; full/empty decoded from the registered count
module tx_fifo
    import uart_pkg::*;
#(
    parameter int unsigned DEPTH = FIFO_DEPTH_DEF,
    localparam int unsigned AW   = $clog2(DEPTH),
    localparam int unsigned CW   = AW + 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [7:0]    din,
    input  logic          wr,
    input  logic          rd,
    output logic [7:0]    dout,
    output logic [CW-1:0] count,
    output logic          full,
    output logic          empty
);

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CW-1:0] count_q, count_d;
    logic          wr_en, rd_en;

    assign full  = (count_q == CW'(DEPTH));
    assign empty = (count_q == '0);
    assign count = count_q;
    assign dout  = mem[rd_ptr_q];

    // full is the registered value, so a write at full is dropped even if
    // a pop happens on the same edge.
    assign wr_en = wr && !full;
    assign rd_en = rd && !empty;

    always_comb begin
        count_d = count_q;
        case ({wr_en, rd_en})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // Depth is a power of two, so pointers wrap by plain overflow.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (wr_en) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (rd_en) rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr_q] <= din;
    end

endmodule

// File: rtl/uart_tx_fifo.sv
// Buffered 8N1 UART transmitter: a byte FIFO drained by a framing FSM.
//   clk   : system clock
//   reset : asynchronous active-low reset; aborts any frame, empties the FIFO
//   bus   : uart_tx_fifo_if slave (din/wr in; tx/full/empty/busy/count/overflow out)
// Frames run back to back while the FIFO has data; tx is a register.
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = CLKS_PER_BIT_DEF,
    parameter int unsigned FIFO_DEPTH   = FIFO_DEPTH_DEF
) (
    input logic        clk,
    input logic        reset,
    uart_tx_fifo_if.slave bus
);

    localparam int unsigned CW        = $clog2(FIFO_DEPTH) + 1;
    localparam logic [15:0] BAUD_LAST = 16'(CLKS_PER_BIT - 1);

    logic [7:0]    fifo_dout;
    logic [CW-1:0] fifo_count;
    logic          fifo_full, fifo_empty;
    logic          pop;

    uart_state_e state_q, state_d;
    logic [15:0] baud_q, baud_d;
    logic [2:0]  bit_idx_q, bit_idx_d;
    logic [7:0]  shreg_q, shreg_d;
    logic        tx_q, tx_d;
    logic        overflow_q;
    logic        bit_done;

    tx_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .din   (bus.din),
        .wr    (bus.wr),
        .rd    (pop),
        .dout  (fifo_dout),
        .count (fifo_count),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign bit_done = (baud_q == BAUD_LAST);

    always_comb begin
        state_d   = state_q;
        baud_d    = baud_q;
        bit_idx_d = bit_idx_q;
        shreg_d   = shreg_q;
        tx_d      = tx_q;
        pop       = 1'b0;

        case (state_q)
            IDLE: begin
                tx_d = 1'b1;
                if (!fifo_empty) begin
                    state_d = START;
                    pop     = 1'b1;
                    shreg_d = fifo_dout;
                    tx_d    = 1'b0;
                    baud_d  = '0;
                end
            end

            START: begin
                if (bit_done) begin
                    state_d   = DATA;
                    baud_d    = '0;
                    bit_idx_d = '0;
                    tx_d      = shreg_q[0];
                    shreg_d   = shreg_q >> 1;
                end else begin
                    baud_d = baud_q + 16'd1;
                end
            end

            DATA: begin
                if (bit_done) begin
                    baud_d = '0;
                    if (bit_idx_q == 3'd7) begin
                        state_d = STOP;
                        tx_d    = 1'b1;
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                        tx_d      = shreg_q[0];
                        shreg_d   = shreg_q >> 1;
                    end
                end else begin
                    baud_d = baud_q + 16'd1;
                end
            end

            STOP: begin
                if (bit_done) begin
                    baud_d = '0;
                    // Chain straight into the next start bit when data waits.
                    if (!fifo_empty) begin
                        state_d = START;
                        pop     = 1'b1;
                        shreg_d = fifo_dout;
                        tx_d    = 1'b0;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    baud_d = baud_q + 16'd1;
                end
            end

            default: begin
                state_d = IDLE;
                tx_d    = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            baud_q    <= '0;
            bit_idx_q <= '0;
            shreg_q   <= '0;
            tx_q      <= 1'b1;
        end else begin
            state_q   <= state_d;
            baud_q    <= baud_d;
            bit_idx_q <= bit_idx_d;
            shreg_q   <= shreg_d;
            tx_q      <= tx_d;
        end
    end

    // Sticky until reset; fifo_full is the same registered flag the FIFO
    // uses to drop the write.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            overflow_q <= 1'b0;
        end else if (bus.wr && fifo_full) begin
            overflow_q <= 1'b1;
        end
    end

    assign bus.tx       = tx_q;
    assign bus.full     = fifo_full;
    assign bus.empty    = fifo_empty;
    assign bus.busy     = (state_q != IDLE);
    assign bus.count    = fifo_count;
    assign bus.overflow = overflow_q;

endmodule
